// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM processor-port arbiter.
// Requester indices, owner-state encoding and counter width helper.
package vram_arb_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;

   localparam int REQ_VGA  = 0;
   localparam int REQ_CORE = 1;
   localparam int NUM_REQ  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      VGA_RD  = 2'd1,
      CORE_RD = 2'd2
   } owner_e;

   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT.
// Used as the core starvation guard in the ARB_STARVE_GUARD_EN build.
module arb_sat_counter
   import vram_arb_pkg::*;
#(
   parameter int LIMIT = 8,
   parameter int W     = cnt_width(LIMIT)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic         at_limit,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] LIM = W'(LIMIT);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && (count != LIM)) begin
         count <= count + 1'b1;
      end
   end

   assign at_limit = (count == LIM);

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates the processor-side VRAM port between VGA fetch and core load/store.
// Build with ARB_STARVE_GUARD_EN to add the core starvation guard.
module vram_port_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W = vram_arb_pkg::ADDR_W,
   parameter int DATA_W = vram_arb_pkg::DATA_W
`ifdef ARB_STARVE_GUARD_EN
   ,
   parameter int CORE_MAX_WAIT = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_rvalid,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   owner_e             state;
   owner_e             state_nxt;
   logic [NUM_REQ-1:0] gnt;
   logic               starve;

`ifdef ARB_STARVE_GUARD_EN
   logic                           at_limit;
   logic [cnt_width(CORE_MAX_WAIT)-1:0] wait_cnt;

   arb_sat_counter #(
      .LIMIT (CORE_MAX_WAIT)
   ) u_wait_cnt (
      .clk      (clk),
      .reset    (reset),
      .inc      (core_req & ~gnt[REQ_CORE]),
      .clr      (gnt[REQ_CORE]),
      .at_limit (at_limit),
      .count    (wait_cnt)
   );

   // Core is forced through only when it would otherwise lose to VGA.
   assign starve = at_limit & vga_req & core_req;
`else
   assign starve = 1'b0;
`endif

   always_comb begin
      gnt = '0;
      if (!reset) begin
         if (vga_req && !starve) begin
            gnt[REQ_VGA] = 1'b1;
         end else if (core_req) begin
            gnt[REQ_CORE] = 1'b1;
         end
      end
   end

   assign vga_gnt  = gnt[REQ_VGA];
   assign core_gnt = gnt[REQ_CORE];

   // Idle port parks on the VGA address so a fresh VGA grant needs no mux change.
   always_comb begin
      mem_addr  = vga_addr;
      mem_we    = 1'b0;
      mem_wdata = core_wdata;
      if (reset) begin
         mem_addr = '0;
      end else if (gnt[REQ_CORE]) begin
         mem_addr = core_addr;
         mem_we   = core_we;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      unique case (1'b1)
         gnt[REQ_VGA]:               state_nxt = VGA_RD;
         gnt[REQ_CORE] && !core_we:  state_nxt = CORE_RD;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Gating with reset drops the in-flight read during the reset cycle itself.
   assign vga_rvalid  = (state == VGA_RD) && !reset;
   assign core_rvalid = (state == CORE_RD) && !reset;
   assign vga_rdata   = mem_rdata;
   assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_vram_port_arbiter;

   localparam int AW   = 15;
   localparam int DW   = 16;
   localparam int MAXW = 8;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_gnt;
   logic [DW-1:0] vga_rdata;
   logic          vga_rvalid;
   logic          core_req;
   logic          core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic          core_gnt;
   logic [DW-1:0] core_rdata;
   logic          core_rvalid;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int passed = 0;
   int total  = 0;

   vram_port_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_gnt     (vga_gnt),
      .vga_rdata   (vga_rdata),
      .vga_rvalid  (vga_rvalid),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rdata  (core_rdata),
      .core_rvalid (core_rvalid),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM with 1-cycle read latency.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   function automatic logic [DW-1:0] pre(input int a);
      if (a == 16) return 16'hBEEF;
      return 16'(a * 7 + 32'h1000);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t",
                    nm, act, exp, $time);
   endtask

   task automatic drive(input logic rst, input logic vr,
                        input logic [AW-1:0] va, input logic cr,
                        input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd);
      @(negedge clk);
      reset      = rst;
      vga_req    = vr;
      vga_addr   = va;
      core_req   = cr;
      core_we    = cw;
      core_addr  = ca;
      core_wdata = cd;
      #2;
   endtask

   typedef struct {
      logic          rst;
      logic          vr;
      logic [AW-1:0] va;
      logic          cr;
      logic          cw;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      logic          egv;
      logic          egc;
      logic          ewe;
      logic [AW-1:0] ea;
      logic          evv;
      logic          ecv;
      logic [DW-1:0] erd;
   } vec_t;

   function automatic vec_t mk(
      input logic rst, input logic vr, input int va,
      input logic cr, input logic cw, input int ca, input int cd,
      input logic egv, input logic egc, input logic ewe, input int ea,
      input logic evv, input logic ecv, input logic [DW-1:0] erd);
      vec_t v;
      v.rst = rst; v.vr = vr; v.va = AW'(va);
      v.cr = cr; v.cw = cw; v.ca = AW'(ca); v.cd = DW'(cd);
      v.egv = egv; v.egc = egc; v.ewe = ewe; v.ea = AW'(ea);
      v.evv = evv; v.ecv = ecv; v.erd = erd;
      return v;
   endfunction

   vec_t tbl [16];

   // Reference model state for the random phase.
   logic [DW-1:0] rmem [16];
   int            pend;
   logic [DW-1:0] pend_d;
   int            wcnt;

   initial begin
      logic          vr, cr, cw, rst;
      logic [AW-1:0] va, ca;
      logic [DW-1:0] cd;
      logic          gv, gc, lgv, lgc, force_c;
      logic [AW-1:0] ea;

      for (int i = 0; i < (1 << AW); i++) ram[i] = pre(i);
      for (int i = 0; i < 16; i++) rmem[i] = pre(32'h100 + i);

      tbl[0]  = mk(1,1,5,     1,1,7,     1,      0,0,0,0,     0,0,0);
      tbl[1]  = mk(1,1,5,     1,1,7,     1,      0,0,0,0,     0,0,0);
      tbl[2]  = mk(0,1,'h10,  0,0,0,     0,      1,0,0,'h10,  0,0,0);
      tbl[3]  = mk(0,0,'h22,  0,0,0,     0,      0,0,0,'h22,  1,0,16'hBEEF);
      tbl[4]  = mk(0,0,0,     1,1,'h1234,'hA5A5, 0,1,1,'h1234,0,0,0);
      tbl[5]  = mk(0,0,0,     1,0,'h1234,0,      0,1,0,'h1234,0,0,0);
      tbl[6]  = mk(0,0,3,     0,0,0,     0,      0,0,0,3,     0,1,16'hA5A5);
      tbl[7]  = mk(0,1,'h40,  1,0,'h41,  0,      1,0,0,'h40,  0,0,0);
      tbl[8]  = mk(0,1,'h40,  1,0,'h41,  0,      1,0,0,'h40,  1,0,pre('h40));
      tbl[9]  = mk(0,1,'h40,  1,0,'h41,  0,      1,0,0,'h40,  1,0,pre('h40));
      tbl[10] = mk(0,1,'h40,  1,0,'h41,  0,      1,0,0,'h40,  1,0,pre('h40));
      tbl[11] = mk(0,0,'h40,  1,0,'h41,  0,      0,1,0,'h41,  1,0,pre('h40));
      tbl[12] = mk(0,0,0,     0,0,0,     0,      0,0,0,0,     0,1,pre('h41));
      tbl[13] = mk(0,0,0,     1,0,'h50,  0,      0,1,0,'h50,  0,0,0);
      tbl[14] = mk(1,0,0,     1,0,'h50,  0,      0,0,0,0,     0,0,0);
      tbl[15] = mk(0,0,'h60,  0,0,0,     0,      0,0,0,'h60,  0,0,0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].rst, tbl[i].vr, tbl[i].va, tbl[i].cr,
               tbl[i].cw, tbl[i].ca, tbl[i].cd);
         chk($sformatf("t%0d vga_gnt", i), 32'(vga_gnt), 32'(tbl[i].egv));
         chk($sformatf("t%0d core_gnt", i), 32'(core_gnt), 32'(tbl[i].egc));
         chk($sformatf("t%0d mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
         chk($sformatf("t%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ea));
         chk($sformatf("t%0d vga_rvalid", i), 32'(vga_rvalid),
             32'(tbl[i].evv));
         chk($sformatf("t%0d core_rvalid", i), 32'(core_rvalid),
             32'(tbl[i].ecv));
         if (tbl[i].ewe)
            chk($sformatf("t%0d mem_wdata", i), 32'(mem_wdata),
                32'(tbl[i].cd));
         if (tbl[i].evv)
            chk($sformatf("t%0d vga_rdata", i), 32'(vga_rdata),
                32'(tbl[i].erd));
         if (tbl[i].ecv)
            chk($sformatf("t%0d core_rdata", i), 32'(core_rdata),
                32'(tbl[i].erd));
      end

      // Sustained contention: fixed priority, or a forced core slot every 9th cycle.
      drive(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) begin
         drive(0, 1, AW'(32'h200 + i), 1, 0, AW'(32'h300), 0);
         force_c = GUARD && ((i % (MAXW + 1)) == MAXW);
         chk($sformatf("cont%0d vga_gnt", i), 32'(vga_gnt), 32'(!force_c));
         chk($sformatf("cont%0d core_gnt", i), 32'(core_gnt), 32'(force_c));
      end
      drive(0, 0, AW'(32'h200), 1, 0, AW'(32'h300), 0);
      chk("drop_vga core_gnt", 32'(core_gnt), 32'd1);
      chk("drop_vga mem_addr", 32'(mem_addr), 32'h300);

      // Randomized traffic against the reference model.
      drive(1, 0, 0, 0, 0, 0, 0);
      pend = 0; wcnt = 0; pend_d = '0;
      vr = 0; cr = 0; cw = 0; va = '0; ca = '0; cd = '0;
      lgv = 0; lgc = 0;
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         if (!vr || lgv) begin
            vr = ($urandom_range(0, 9) < 7);
            va = AW'(32'h100 + $urandom_range(0, 15));
         end
         if (!cr || lgc) begin
            cr = ($urandom_range(0, 9) < 6);
            cw = $urandom_range(0, 1) == 1;
            ca = AW'(32'h100 + $urandom_range(0, 15));
            cd = DW'($urandom);
         end
         drive(rst, vr, va, cr, cw, ca, cd);

         force_c = GUARD && (wcnt >= MAXW) && vr && cr;
         gv = !rst && vr && !force_c;
         gc = !rst && cr && !gv;
         ea = rst ? '0 : (gc ? ca : va);
         chk("rnd vga_gnt", 32'(vga_gnt), 32'(gv));
         chk("rnd core_gnt", 32'(core_gnt), 32'(gc));
         chk("rnd mem_we", 32'(mem_we), 32'(gc && cw));
         chk("rnd mem_addr", 32'(mem_addr), 32'(ea));
         if (gc && cw) chk("rnd mem_wdata", 32'(mem_wdata), 32'(cd));
         chk("rnd vga_rvalid", 32'(vga_rvalid), 32'(!rst && pend == 1));
         chk("rnd core_rvalid", 32'(core_rvalid), 32'(!rst && pend == 2));
         if (!rst && pend == 1) chk("rnd vga_rdata", 32'(vga_rdata), 32'(pend_d));
         if (!rst && pend == 2) chk("rnd core_rdata", 32'(core_rdata), 32'(pend_d));

         if (rst) begin
            pend = 0;
            wcnt = 0;
         end else begin
            if (gc && cw) rmem[ca[3:0]] = cd;
            pend   = gv ? 1 : ((gc && !cw) ? 2 : 0);
            pend_d = gv ? rmem[va[3:0]] : rmem[ca[3:0]];
            if (gc) wcnt = 0;
            else if (cr && wcnt < MAXW) wcnt++;
         end
         lgv = gv;
         lgc = gc;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
